// File: rtl/if_fetch_unit_pkg.sv
// Shared IF-stage constants and types: fetch FSM states and the IF/ID bundle
// that the ID stage also consumes.
package if_fetch_unit_pkg;

   localparam int          PC_W      = 32;
   localparam int          ROM_AW    = 6;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FAULT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic            valid;
      logic [PC_W-1:0] pc;
      logic [PC_W-1:0] pc_plus4;
      logic [31:0]     instr;
   } if_id_t;

   // True when the byte address falls inside the ROM's fetchable window.
   function automatic logic addr_in_range(input logic [PC_W-1:0] addr);
      return addr[PC_W-1:ROM_AW+2] == '0;
   endfunction

endpackage

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register. Flush wins over hold; a flush only kills valid and
// the instruction word, the pc fields keep their last value.
module if_id_reg
   import if_fetch_unit_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   hold,
   input  logic   flush,
   input  if_id_t d,
   output if_id_t q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q.valid    <= 1'b0;
         q.pc       <= '0;
         q.pc_plus4 <= '0;
         q.instr    <= NOP_INSTR;
      end else if (flush) begin
         q.valid <= 1'b0;
         q.instr <= NOP_INSTR;
      end else if (!hold) begin
         q <= d;
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage fetch control: owns the PC, addresses the instruction ROM and
// fills IF/ID, handling stall, redirect/flush and sticky fetch faults.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   ST_RUN   | normal fetch, redirect and stall honoured
//   ST_FAULT | terminal after a bad fetch address; reset only
module if_fetch_unit
   import if_fetch_unit_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [31:0]       rom_data,
   output logic              if_id_valid,
   output logic [PC_W-1:0]   if_id_pc,
   output logic [PC_W-1:0]   if_id_pc_plus4,
   output logic [31:0]       if_id_instr,
   output logic              fetch_fault,
   output logic [PC_W-1:0]   fault_pc,
   output logic [31:0]       fetch_count
);

   fetch_state_t    state;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_plus4;
   logic            run;
   logic            redir_bad;
   logic            pc_oor;
   logic            fault_det;
   logic            redir_take;
   logic            advance;
   if_id_t          if_id_d;
   if_id_t          if_id_q;

   assign pc_plus4 = pc + PC_W'(4);
   assign rom_addr = pc[ROM_AW+1:2];

   // A redirect target is checked up front so the fault reports the target,
   // not the PC that happened to be in flight.
   assign run        = (state == ST_RUN);
   assign redir_bad  = redirect_valid &&
                       ((redirect_pc[1:0] != 2'b00) || !addr_in_range(redirect_pc));
   assign pc_oor     = !addr_in_range(pc);
   assign fault_det  = run && (redir_bad || pc_oor);
   assign redir_take = run && !fault_det && redirect_valid;
   assign advance    = run && !fault_det && !redirect_valid && !stall;

   assign if_id_d.valid    = 1'b1;
   assign if_id_d.pc       = pc;
   assign if_id_d.pc_plus4 = pc_plus4;
   assign if_id_d.instr    = rom_data;

   if_id_reg u_if_id_reg (
      .clk   (clk),
      .reset (reset),
      .hold  (!advance),
      .flush (fault_det || redir_take),
      .d     (if_id_d),
      .q     (if_id_q)
   );

   assign if_id_valid    = if_id_q.valid;
   assign if_id_pc       = if_id_q.pc;
   assign if_id_pc_plus4 = if_id_q.pc_plus4;
   assign if_id_instr    = if_id_q.instr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_RUN;
         pc          <= RESET_PC;
         fetch_fault <= 1'b0;
         fault_pc    <= '0;
         fetch_count <= '0;
      end else if (fault_det) begin
         state       <= ST_FAULT;
         fetch_fault <= 1'b1;
         fault_pc    <= redir_bad ? redirect_pc : pc;
      end else if (redir_take) begin
         pc <= redirect_pc;
      end else if (advance) begin
         pc          <= pc_plus4;
         fetch_count <= fetch_count + 32'd1;
      end
   end

endmodule
